// File: rtl/adc_block_avg.sv
// Block averager for the dual-channel ADC stream: one truncated mean,
// overrange flag and running peak per channel for every 2^LOG2_N samples.
module adc_block_avg #(
  parameter int DATA_W     = 12,
  parameter int LOG2_N     = 4,
  parameter int OVR_THRESH = 4095
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              hold_i,
  input  logic              clear_i,
  input  logic              data_update_i,
  input  logic [DATA_W-1:0] data0_i,
  input  logic [DATA_W-1:0] data1_i,
  output logic              avg_valid_o,
  output logic [DATA_W-1:0] avg0_o,
  output logic [DATA_W-1:0] avg1_o,
  output logic              ovr0_o,
  output logic              ovr1_o,
  output logic [DATA_W-1:0] max0_o,
  output logic [DATA_W-1:0] max1_o
);

  localparam int AW = DATA_W + LOG2_N;
  // keep the counter at least one bit wide so LOG2_N=0 still elaborates
  localparam int CW = (LOG2_N > 0) ? LOG2_N : 1;
  localparam logic [CW-1:0] LAST = CW'((1 << LOG2_N) - 1);
  localparam logic [DATA_W-1:0] THR = DATA_W'(OVR_THRESH);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t          state;
  logic [AW-1:0]   acc0;
  logic [AW-1:0]   acc1;
  logic [CW-1:0]   cnt;
  logic            pend0;
  logic            pend1;
  logic [AW-1:0]   sum0;
  logic [AW-1:0]   sum1;
  logic            hit0;
  logic            hit1;
  logic            flush;
  logic            accept;
  logic            last;

  assign sum0   = acc0 + AW'(data0_i);
  assign sum1   = acc1 + AW'(data1_i);
  assign hit0   = data0_i >= THR;
  assign hit1   = data1_i >= THR;
  assign flush  = clear_i || !en_i || (state == IDLE);
  assign accept = !flush && data_update_i;
  assign last   = cnt == LAST;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc0        <= '0;
      acc1        <= '0;
      cnt         <= '0;
      pend0       <= 1'b0;
      pend1       <= 1'b0;
      avg_valid_o <= 1'b0;
      avg0_o      <= '0;
      avg1_o      <= '0;
      ovr0_o      <= 1'b0;
      ovr1_o      <= 1'b0;
      max0_o      <= '0;
      max1_o      <= '0;
    end else begin
      avg_valid_o <= 1'b0;

      unique case (state)
        IDLE:    if (en_i)  state <= ACCUM;
        ACCUM:   if (!en_i) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (flush || (accept && last)) begin
        acc0  <= '0;
        acc1  <= '0;
        cnt   <= '0;
        pend0 <= 1'b0;
        pend1 <= 1'b0;
      end else if (accept) begin
        acc0  <= sum0;
        acc1  <= sum1;
        cnt   <= cnt + CW'(1);
        pend0 <= pend0 | hit0;
        pend1 <= pend1 | hit1;
      end

      if (accept && last && !hold_i) begin
        avg0_o      <= sum0[AW-1:LOG2_N];
        avg1_o      <= sum1[AW-1:LOG2_N];
        ovr0_o      <= pend0 | hit0;
        ovr1_o      <= pend1 | hit1;
        avg_valid_o <= 1'b1;
      end

      // an explicit clear takes precedence over a frozen display
      if (clear_i) begin
        max0_o <= '0;
        max1_o <= '0;
      end else if (accept && !hold_i) begin
        if (data0_i > max0_o) max0_o <= data0_i;
        if (data1_i > max1_o) max1_o <= data1_i;
      end
    end
  end

endmodule

// File: tb/tb_adc_block_avg.sv
// Scoreboard bench for adc_block_avg: directed blocks push expected
// publishes; a negedge monitor pops and checks values and latency.
module tb_adc_block_avg;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_i;
  logic        hold_i;
  logic        clear_i;
  logic        data_update_i;
  logic [11:0] data0_i;
  logic [11:0] data1_i;
  logic        avg_valid_o;
  logic [11:0] avg0_o;
  logic [11:0] avg1_o;
  logic        ovr0_o;
  logic        ovr1_o;
  logic [11:0] max0_o;
  logic [11:0] max1_o;

  adc_block_avg dut (
    .clk(clk),
    .rst(rst),
    .en_i(en_i),
    .hold_i(hold_i),
    .clear_i(clear_i),
    .data_update_i(data_update_i),
    .data0_i(data0_i),
    .data1_i(data1_i),
    .avg_valid_o(avg_valid_o),
    .avg0_o(avg0_o),
    .avg1_o(avg1_o),
    .ovr0_o(ovr0_o),
    .ovr1_o(ovr1_o),
    .max0_o(max0_o),
    .max1_o(max1_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] a0;
    logic [11:0] a1;
    logic        o0;
    logic        o1;
    logic [11:0] m0;
    logic [11:0] m1;
    int          c;
  } exp_t;

  exp_t q[$];
  exp_t nxt;
  bit   arm = 1'b0;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (avg_valid_o === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse got avg0=%0d avg1=%0d exp none",
                 avg0_o, avg1_o);
      end else begin
        e = q.pop_front();
        chk("pub_avg0", avg0_o, e.a0);
        chk("pub_avg1", avg1_o, e.a1);
        chk("pub_ovr0", ovr0_o, e.o0);
        chk("pub_ovr1", ovr1_o, e.o1);
        chk("pub_max0", max0_o, e.m0);
        chk("pub_max1", max1_o, e.m1);
        chk("pub_latency", cyc, e.c);
      end
    end
  end

  task automatic pulse(input logic [11:0] a, input logic [11:0] b,
                       input bit gap);
    @(negedge clk);
    if (arm) begin
      nxt.c = cyc + 1;
      q.push_back(nxt);
      arm = 1'b0;
    end
    data_update_i = 1'b1;
    data0_i = a;
    data1_i = b;
    if (gap) begin
      @(negedge clk);
      data_update_i = 1'b0;
    end
  endtask

  task automatic block(input logic [11:0] a, input logic [11:0] b,
                       input int n, input bit gap, input bit ex);
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) arm = ex;
      pulse(a, b, gap);
    end
    if (!gap) begin
      @(negedge clk);
      data_update_i = 1'b0;
    end
  endtask

  task automatic drain(input string nm);
    int k = 0;
    while (q.size() > 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL %s got pending=%0d exp pending=0", nm, q.size());
      q.delete();
    end
  endtask

  task automatic chk_outs(input string nm,
                          input logic [11:0] a0, input logic [11:0] a1,
                          input logic o0, input logic o1,
                          input logic [11:0] m0, input logic [11:0] m1);
    chk({nm, "_avg0"}, avg0_o, a0);
    chk({nm, "_avg1"}, avg1_o, a1);
    chk({nm, "_ovr0"}, ovr0_o, o0);
    chk({nm, "_ovr1"}, ovr1_o, o1);
    chk({nm, "_max0"}, max0_o, m0);
    chk({nm, "_max1"}, max1_o, m1);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    en_i = 1'b0;
    hold_i = 1'b0;
    clear_i = 1'b0;
    data_update_i = 1'b0;
    data0_i = '0;
    data1_i = '0;
    repeat (3) @(negedge clk);
    chk_outs("reset", 0, 0, 0, 0, 0, 0);
    chk("reset_valid", avg_valid_o, 0);
    rst = 1'b0;
    en_i = 1'b1;
    repeat (2) @(negedge clk);

    nxt = '{12'd1000, 12'd1000, 1'b0, 1'b0, 12'd1000, 12'd1000, 0};
    block(12'd1000, 12'd1000, 16, 1'b1, 1'b1);
    drain("blk_const");

    @(negedge clk);
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    chk_outs("clr_idle", 1000, 1000, 0, 0, 0, 0);

    nxt = '{12'd7, 12'd7, 1'b0, 1'b0, 12'd15, 12'd7, 0};
    for (int i = 0; i < 16; i++) begin
      arm = (i == 15);
      pulse(12'(i), 12'd7, 1'b1);
    end
    drain("blk_ramp");

    nxt = '{12'd4095, 12'd0, 1'b1, 1'b0, 12'd4095, 12'd7, 0};
    block(12'd4095, 12'd0, 16, 1'b0, 1'b1);
    drain("blk_full_b2b");

    nxt = '{12'd2000, 12'd2000, 1'b0, 1'b0, 12'd4095, 12'd2000, 0};
    block(12'd2000, 12'd2000, 16, 1'b1, 1'b1);
    drain("blk_ovr_clear");

    @(negedge clk);
    hold_i = 1'b1;
    block(12'd300, 12'd300, 16, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk_outs("hold", 2000, 2000, 0, 0, 4095, 2000);
    hold_i = 1'b0;
    nxt = '{12'd500, 12'd500, 1'b0, 1'b0, 12'd4095, 12'd2000, 0};
    block(12'd500, 12'd500, 16, 1'b1, 1'b1);
    drain("blk_after_hold");

    block(12'd100, 12'd100, 7, 1'b1, 1'b0);
    @(negedge clk);
    clear_i = 1'b1;
    data_update_i = 1'b1;
    data0_i = 12'd3000;
    data1_i = 12'd3000;
    @(negedge clk);
    clear_i = 1'b0;
    data_update_i = 1'b0;
    chk_outs("clr_mid", 500, 500, 0, 0, 0, 0);
    nxt = '{12'd200, 12'd200, 1'b0, 1'b0, 12'd200, 12'd200, 0};
    block(12'd200, 12'd200, 16, 1'b1, 1'b1);
    drain("blk_after_clr");

    block(12'd50, 12'd50, 4, 1'b1, 1'b0);
    @(negedge clk);
    en_i = 1'b0;
    data_update_i = 1'b1;
    data0_i = 12'd50;
    data1_i = 12'd50;
    @(negedge clk);
    data_update_i = 1'b0;
    en_i = 1'b1;
    @(negedge clk);
    chk_outs("en_low", 200, 200, 0, 0, 200, 200);

    block(12'd60, 12'd60, 15, 1'b1, 1'b0);
    @(negedge clk);
    en_i = 1'b0;
    data_update_i = 1'b1;
    data0_i = 12'd60;
    data1_i = 12'd60;
    @(negedge clk);
    data_update_i = 1'b0;
    en_i = 1'b1;
    @(negedge clk);
    nxt = '{12'd800, 12'd800, 1'b0, 1'b0, 12'd800, 12'd800, 0};
    block(12'd800, 12'd800, 16, 1'b1, 1'b1);
    drain("blk_after_en");

    block(12'd900, 12'd900, 9, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    data_update_i = 1'b1;
    data0_i = 12'd900;
    data1_i = 12'd900;
    @(negedge clk);
    data_update_i = 1'b0;
    chk_outs("mid_rst", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);
    nxt = '{12'd1234, 12'd4095, 1'b0, 1'b1, 12'd1234, 12'd4095, 0};
    block(12'd1234, 12'd4095, 16, 1'b1, 1'b1);
    drain("blk_after_rst");

    repeat (5) @(negedge clk);
    chk("final_queue", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_block_avg.md
Name: adc_block_avg

Overview:
- Sits directly downstream of the dual-channel 12-bit SPI ADC reader in the multimeter datapath.
- Consumes each (data_update, data0, data1) sample pair and accumulates 2^LOG2_N samples per channel.
- Emits one truncated block average per channel, with a per-block overrange flag and a running peak (max) per channel.
- Feeds the display/scaling stage, which sees one averaged reading per block instead of raw ADC samples.

Parameters:
DATA_W, 12, sample width per channel
LOG2_N, 4, log2 of samples per average block; legal range 0..8 (0 = pass-through, 1 sample per block)
OVR_THRESH, 4095, sample value at or above which the overrange flag is set

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  reset, synchronous, active-high
en_i  in  1  enable; low forces IDLE
hold_i  in  1  freeze displayed outputs; accumulation continues
clear_i  in  1  single-cycle pulse: restart block and clear peaks
data_update_i  in  1  one-cycle strobe, new sample pair valid
data0_i  in  DATA_W  channel 0 sample
data1_i  in  DATA_W  channel 1 sample
avg_valid_o  out  1  one-cycle strobe, new averages on avg*_o
avg0_o  out  DATA_W  channel 0 block average
avg1_o  out  DATA_W  channel 1 block average
ovr0_o  out  1  channel 0 overrange within last published block
ovr1_o  out  1  channel 1 overrange within last published block
max0_o  out  DATA_W  channel 0 peak since last clear
max1_o  out  DATA_W  channel 1 peak since last clear

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE, all outputs 0, accumulators/counter/overrange-accumulators 0. Overrides everything, including mid-block.
- States: IDLE, ACCUM.
  - IDLE -> ACCUM when en_i=1.
  - ACCUM -> IDLE when en_i=0; this clears accumulators, counter and pending ovr bits.
  - Outputs (avg, ovr, max) are retained in IDLE.
- Accumulator width: DATA_W+LOG2_N bits per channel. No overflow possible; 2^N x 4095 fits. Sample counter is LOG2_N bits, wraps naturally.
- Accepted sample: data_update_i=1 in ACCUM with clear_i=0.
  - acc += data, cnt += 1.
  - Pending ovr bit |= (data >= OVR_THRESH).
- Block completion: accepted sample with cnt == 2^LOG2_N-1.
  - At the next edge: avg = (acc+data) >> LOG2_N (truncate, no rounding). ovr = pending | current-sample compare. avg_valid_o=1 for exactly that one cycle.
  - acc, cnt and pending ovr are reset in that same edge.
  - Latency: avg_valid_o is high in the cycle after the final data_update_i cycle.
- Peak: on each accepted sample, max_o <= data if data > max_o (per channel, independent).
- hold_i=1:
  - avg_o, ovr_o and max_o do not change; avg_valid_o stays 0.
  - Accumulation and block counting continue; a block completing during hold is discarded.
  - The first block completing after hold falls publishes normally.
- clear_i=1 (any state except reset): acc, cnt, pending ovr -> 0; max0_o, max1_o -> 0.
  - avg_o and ovr_o keep their values.
  - clear_i with data_update_i in the same cycle: clear wins and the sample is discarded.
- en_i falling in the same cycle as a completing sample: en_i wins, no publish.
- Samples arriving while in IDLE are ignored.
- data_update_i is assumed at most every 2 cycles (ADC rate), but must also work for back-to-back strobes.

Test Plan:
- LOG2_N=4, 16 strobes with both channels 1000 -> one avg_valid_o pulse one cycle after the 16th strobe; avg0/1=1000, ovr=0, max=1000.
- Ch0 ramp 0..15, ch1 constant 7 -> avg0=7 (120>>4, truncation), avg1=7, max0=15.
- 16 strobes of 4095 on ch0, 0 on ch1 -> avg0=4095 (no accumulator wrap), ovr0=1, ovr1=0; a following block of 2000 -> ovr0=0.
- Hold asserted across a completing block, then released; next block of 500s -> no pulse during hold, outputs keep the prior value, then avg=500 one cycle after the 16th post-hold-block strobe.
- clear_i coincident with the 8th strobe of a block -> that sample is dropped, max cleared; the next 16 samples form a full block (pulse after strobe 24 total).
- rst at strobe 10 and en_i low at strobe 5 -> all outputs 0 after rst; no publish; counter restarts from 0 on the next block.
